// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with sync, blanking
// and frame markers, plus a configurable delay line on the sync/visible flags.
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIPE_DELAY  = 2,
  parameter int SCALE_SHIFT = 0,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   resync,
  output logic [COORD_WIDTH-1:0] hpos,
  output logic [COORD_WIDTH-1:0] vpos,
  output logic [COORD_WIDTH-1:0] hpos_scaled,
  output logic [COORD_WIDTH-1:0] vpos_scaled,
  output logic                   display_on,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic                   vblank_start,
  output logic [15:0]            frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_WIDTH-1:0] H_LAST     = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST     = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_ACT_END  = COORD_WIDTH'(H_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] V_ACT_END  = COORD_WIDTH'(V_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] HS_START   = COORD_WIDTH'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_WIDTH-1:0] HS_END     = COORD_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_WIDTH-1:0] VS_START   = COORD_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_WIDTH-1:0] VS_END     = COORD_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [COORD_WIDTH-1:0] COORD_ONE  = COORD_WIDTH'(1);

  if (H_TOTAL > (1 << COORD_WIDTH)) begin : g_bad_htotal
    $error("video_timing_gen: H_TOTAL does not fit in COORD_WIDTH");
  end
  if (V_TOTAL > (1 << COORD_WIDTH)) begin : g_bad_vtotal
    $error("video_timing_gen: V_TOTAL does not fit in COORD_WIDTH");
  end
  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
    $error("video_timing_gen: porch and sync widths must be at least 1");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("video_timing_gen: PIPE_DELAY must be within 0..8");
  end

  logic [COORD_WIDTH-1:0] hpos_q, hpos_d;
  logic [COORD_WIDTH-1:0] vpos_q, vpos_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [PIPE_DELAY:0]    disp_pipe_q, disp_pipe_d;
  logic [PIPE_DELAY:0]    hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY:0]    vs_pipe_q, vs_pipe_d;
  logic                   h_wrap, v_wrap;
  logic                   disp_raw, hs_raw, vs_raw;

  // resync wins over the end-of-frame wrap, so the frame counter holds
  always_comb begin
    h_wrap        = (hpos_q == H_LAST);
    v_wrap        = (vpos_q == V_LAST);
    hpos_d        = h_wrap ? '0 : hpos_q + COORD_ONE;
    vpos_d        = vpos_q;
    frame_count_d = frame_count_q;
    if (h_wrap) begin
      vpos_d = v_wrap ? '0 : vpos_q + COORD_ONE;
      if (v_wrap) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
    if (resync) begin
      hpos_d        = '0;
      vpos_d        = '0;
      frame_count_d = frame_count_q;
    end
  end

  always_comb begin
    disp_raw = (hpos_q < H_ACT_END) && (vpos_q < V_ACT_END);
    hs_raw   = ((hpos_q >= HS_START) && (hpos_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_raw   = ((vpos_q >= VS_START) && (vpos_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    disp_pipe_d    = disp_pipe_q;
    hs_pipe_d      = hs_pipe_q;
    vs_pipe_d      = vs_pipe_q;
    disp_pipe_d[0] = disp_raw;
    hs_pipe_d[0]   = hs_raw;
    vs_pipe_d[0]   = vs_raw;
    for (int i = 1; i <= PIPE_DELAY; i++) begin
      disp_pipe_d[i] = disp_pipe_q[i-1];
      hs_pipe_d[i]   = hs_pipe_q[i-1];
      vs_pipe_d[i]   = vs_pipe_q[i-1];
    end
  end

  // the delay line is deliberately left running on resync so old values drain out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_count_q <= '0;
      disp_pipe_q   <= '0;
      hs_pipe_q     <= {(PIPE_DELAY+1){~HSYNC_POL}};
      vs_pipe_q     <= {(PIPE_DELAY+1){~VSYNC_POL}};
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
      disp_pipe_q   <= disp_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  assign hpos         = hpos_q;
  assign vpos         = vpos_q;
  assign hpos_scaled  = hpos_q >> SCALE_SHIFT;
  assign vpos_scaled  = vpos_q >> SCALE_SHIFT;
  assign display_on   = disp_pipe_q[PIPE_DELAY];
  assign hsync        = hs_pipe_q[PIPE_DELAY];
  assign vsync        = vs_pipe_q[PIPE_DELAY];
  assign frame_start  = (hpos_q == '0) && (vpos_q == '0);
  assign vblank_start = (hpos_q == '0) && (vpos_q == V_ACT_END);
  assign frame_count  = frame_count_q;

endmodule
